// File: rtl/majority_vote_tally_if.sv
// Voting bus between a requester and the majority_vote_tally block.
// master: drives start/vote_valid/vote_yes and observes the round status.
// slave : the tally block; observes requests and drives status and tallies.
//   start      - opens a round (honoured only when the block is idle)
//   vote_valid - per-voter vote strobe
//   vote_yes   - per-voter vote value (1 = yes)
//   busy       - round in progress (collecting or closing)
//   voted      - mask of voters counted this round
//   yes_count  - yes tally
//   no_count   - no tally
//   done       - one-cycle pulse when the round closes
//   result     - yes_count reached the threshold
//   timed_out  - round closed by timeout
interface majority_vote_tally_if #(
    parameter int unsigned N_VOTERS = 5
) ();
    localparam int unsigned CW = $clog2(N_VOTERS + 1);

    logic                start;
    logic [N_VOTERS-1:0] vote_valid;
    logic [N_VOTERS-1:0] vote_yes;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [CW-1:0]       yes_count;
    logic [CW-1:0]       no_count;
    logic                done;
    logic                result;
    logic                timed_out;

    modport master (
        output start, vote_valid, vote_yes,
        input  busy, voted, yes_count, no_count, done, result, timed_out
    );

    modport slave (
        input  start, vote_valid, vote_yes,
        output busy, voted, yes_count, no_count, done, result, timed_out
    );
endinterface

// File: rtl/majority_vote_tally.sv
// Sequential N-voter majority tally. A round opens on start, collects at most
// one vote per voter, and closes when everyone has voted or after TIMEOUT
// collect cycles. The round result and tallies are held until the next start.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - majority_vote_tally_if slave modport (requests in, status out)
module majority_vote_tally #(
    parameter int unsigned N_VOTERS  = 5,
    parameter int unsigned THRESHOLD = 0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    majority_vote_tally_if.slave  bus
);
    localparam int unsigned CW    = $clog2(N_VOTERS + 1);
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned EFF_T = (THRESHOLD != 0) ? THRESHOLD : (N_VOTERS / 2 + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CW-1:0]       yes_q, yes_d;
    logic [CW-1:0]       no_q, no_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                result_q, result_d;
    logic                tmo_q, tmo_d;

    logic [N_VOTERS-1:0] new_mask;
    logic [CW-1:0]       yes_add;
    logic [CW-1:0]       no_add;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            voted_q  <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            timer_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            voted_q  <= voted_d;
            yes_q    <= yes_d;
            no_q     <= no_d;
            timer_q  <= timer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state and tally logic
    always_comb begin
        state_d  = state_q;
        voted_d  = voted_q;
        yes_d    = yes_q;
        no_d     = no_q;
        timer_d  = timer_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        tmo_d    = tmo_q;

        // First-time voters only; repeat votes from counted voters drop out here
        new_mask = bus.vote_valid & ~voted_q;
        yes_add  = '0;
        no_add   = '0;
        for (int unsigned i = 0; i < N_VOTERS; i++) begin
            if (new_mask[i]) begin
                if (bus.vote_yes[i]) begin
                    yes_add = yes_add + CW'(1);
                end else begin
                    no_add = no_add + CW'(1);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_COLLECT;
                    voted_d  = '0;
                    yes_d    = '0;
                    no_d     = '0;
                    timer_d  = '0;
                    result_d = 1'b0;
                    tmo_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            S_COLLECT: begin
                voted_d = voted_q | new_mask;
                yes_d   = yes_q + yes_add;
                no_d    = no_q + no_add;
                timer_d = timer_q + TW'(1);
                // All-voted takes priority over a coincident timeout
                if (&voted_d) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    tmo_d    = 1'b0;
                    result_d = (32'(yes_d) >= EFF_T);
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    tmo_d    = 1'b1;
                    result_d = (32'(yes_d) >= EFF_T);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.voted     = voted_q;
    assign bus.yes_count = yes_q;
    assign bus.no_count  = no_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.timed_out = tmo_q;
endmodule

// File: tb/tb_majority_vote_tally.sv
// Bench for majority_vote_tally: three instances (N=5 default threshold,
// N=5 threshold 2, N=4 default threshold) share one stimulus stream; the N=4
// instance sees voters 0..3. Each round is planned as per-voter arrival cycles,
// expected outcomes are pushed to per-instance queues and popped on done.
module tb_majority_vote_tally;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [4:0] voted;
        int         yes;
        int         no;
        bit         result;
        bit         tmo;
        int         close;
        int         done_cyc;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [4:0] vv;
    logic [4:0] vy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Round plan: arrival cycle per voter (0 = never) and vote value
    int arr [5];
    bit val [5];

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    bit pend_a, pend_b, pend_c;

    majority_vote_tally_if #(.N_VOTERS(5)) if_a ();
    majority_vote_tally_if #(.N_VOTERS(5)) if_b ();
    majority_vote_tally_if #(.N_VOTERS(4)) if_c ();

    assign if_a.start      = start;
    assign if_a.vote_valid = vv;
    assign if_a.vote_yes   = vy;
    assign if_b.start      = start;
    assign if_b.vote_valid = vv;
    assign if_b.vote_yes   = vy;
    assign if_c.start      = start;
    assign if_c.vote_valid = vv[3:0];
    assign if_c.vote_yes   = vy[3:0];

    majority_vote_tally #(.N_VOTERS(5), .THRESHOLD(0), .TIMEOUT(TIMEOUT)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(if_a));
    majority_vote_tally #(.N_VOTERS(5), .THRESHOLD(2), .TIMEOUT(TIMEOUT)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(if_b));
    majority_vote_tally #(.N_VOTERS(4), .THRESHOLD(0), .TIMEOUT(TIMEOUT)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    // Round outcome from the voting rules: who arrived in time, when it closes
    function automatic exp_t model(input int n, input int thr, input int p);
        exp_t e;
        bit   all_in;
        int   last;
        int   t;
        all_in = 1'b1;
        last   = 0;
        for (int i = 0; i < n; i++) begin
            if (arr[i] == 0 || arr[i] > TIMEOUT) all_in = 1'b0;
            else if (arr[i] > last) last = arr[i];
        end
        e.close = all_in ? last : TIMEOUT;
        e.tmo   = !all_in;
        e.voted = '0;
        e.yes   = 0;
        e.no    = 0;
        for (int i = 0; i < n; i++) begin
            if (arr[i] != 0 && arr[i] <= e.close) begin
                e.voted[i] = 1'b1;
                if (val[i]) e.yes++;
                else        e.no++;
            end
        end
        t = (thr != 0) ? thr : (n / 2 + 1);
        e.result   = (e.yes >= t);
        e.done_cyc = p + 1 + e.close;
        return e;
    endfunction

    task automatic cmp_exp(input string tag, input exp_t e, input logic [4:0] voted,
                           input int yes, input int no, input logic res,
                           input logic tmo, input logic busy);
        check({tag, ".done_cycle"}, cyc, e.done_cyc);
        check({tag, ".voted"}, int'(voted), int'(e.voted));
        check({tag, ".yes_count"}, yes, e.yes);
        check({tag, ".no_count"}, no, e.no);
        check({tag, ".result"}, int'(res), int'(e.result));
        check({tag, ".timed_out"}, int'(tmo), int'(e.tmo));
        check({tag, ".busy_in_done"}, int'(busy), 1);
    endtask

    task automatic unexpected_done(input string tag);
        checks++;
        errors++;
        $display("FAIL %s.unexpected_done: got done=1 expected no pending round (cycle %0d)", tag, cyc);
    endtask

    // Monitors: pop an expectation on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) pend_a = 1'b0;
        else begin
            if (pend_a) begin
                check("a.done_pulse_width", int'(if_a.done), 0);
                check("a.busy_after_done", int'(if_a.busy), 0);
                pend_a = 1'b0;
            end
            if (if_a.done) begin
                pend_a = 1'b1;
                if (q_a.size() == 0) unexpected_done("a");
                else begin
                    e = q_a.pop_front();
                    cmp_exp("a", e, if_a.voted, int'(if_a.yes_count), int'(if_a.no_count),
                            if_a.result, if_a.timed_out, if_a.busy);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) pend_b = 1'b0;
        else begin
            if (pend_b) begin
                check("b.done_pulse_width", int'(if_b.done), 0);
                check("b.busy_after_done", int'(if_b.busy), 0);
                pend_b = 1'b0;
            end
            if (if_b.done) begin
                pend_b = 1'b1;
                if (q_b.size() == 0) unexpected_done("b");
                else begin
                    e = q_b.pop_front();
                    cmp_exp("b", e, if_b.voted, int'(if_b.yes_count), int'(if_b.no_count),
                            if_b.result, if_b.timed_out, if_b.busy);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) pend_c = 1'b0;
        else begin
            if (pend_c) begin
                check("c.done_pulse_width", int'(if_c.done), 0);
                check("c.busy_after_done", int'(if_c.busy), 0);
                pend_c = 1'b0;
            end
            if (if_c.done) begin
                pend_c = 1'b1;
                if (q_c.size() == 0) unexpected_done("c");
                else begin
                    e = q_c.pop_front();
                    cmp_exp("c", e, 5'(if_c.voted), int'(if_c.yes_count), int'(if_c.no_count),
                            if_c.result, if_c.timed_out, if_c.busy);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, ".a"}, int'({if_a.busy, if_a.done, if_a.result, if_a.timed_out,
                                 if_a.voted, if_a.yes_count, if_a.no_count}), 0);
        check({tag, ".b"}, int'({if_b.busy, if_b.done, if_b.result, if_b.timed_out,
                                 if_b.voted, if_b.yes_count, if_b.no_count}), 0);
        check({tag, ".c"}, int'({if_c.busy, if_c.done, if_c.result, if_c.timed_out,
                                 if_c.voted, if_c.yes_count, if_c.no_count}), 0);
    endtask

    // Play one round from the plan in arr/val; called just after a rising edge.
    // noise adds repeat votes with flipped values and stray mid-round starts.
    task automatic play_round(input bit noise);
        exp_t ea, eb, ec;
        int   minc;
        ea = model(5, 0, cyc);
        eb = model(5, 2, cyc);
        ec = model(4, 0, cyc);
        q_a.push_back(ea);
        q_b.push_back(eb);
        q_c.push_back(ec);
        minc = ea.close;
        if (eb.close < minc) minc = eb.close;
        if (ec.close < minc) minc = ec.close;

        start = 1'b1;
        vv    = 5'($urandom);
        vy    = 5'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            start = noise && (c <= minc) && ($urandom_range(0, 3) == 0);
            vv    = '0;
            vy    = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                if (arr[i] == c) begin
                    vv[i] = 1'b1;
                    vy[i] = val[i];
                end else if (noise && arr[i] != 0 && arr[i] < c && $urandom_range(0, 1) == 1) begin
                    vv[i] = 1'b1;
                    vy[i] = ~val[i];
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat ($urandom_range(2, 4)) begin
            vv = 5'($urandom);
            vy = 5'($urandom);
            @(posedge clk); #1;
        end
        vv = '0;
    endtask

    task automatic set_plan(input int a0, a1, a2, a3, a4, input logic [4:0] v);
        arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = a3; arr[4] = a4;
        for (int i = 0; i < 5; i++) val[i] = v[i];
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        vv      = '0;
        vy      = '0;
        #12;
        check_all_zero("reset_state");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Everyone votes on the first collect cycle
        set_plan(1, 1, 1, 1, 1, 5'b00111);
        play_round(1'b0);
        // Voter 0 early yes, repeats flipped; the rest vote no later
        set_plan(1, 3, 3, 3, 3, 5'b00001);
        play_round(1'b1);
        // Only voters 0 and 1 vote: timeout path
        set_plan(1, 1, 0, 0, 0, 5'b00011);
        play_round(1'b1);
        // 2-2 tie for N=4 with the last voter on the final collect edge
        set_plan(1, 1, 1, TIMEOUT, 0, 5'b00011);
        play_round(1'b0);
        // All five arrive on the final collect edge: all-voted beats timeout
        set_plan(TIMEOUT, TIMEOUT, TIMEOUT, TIMEOUT, TIMEOUT, 5'b10101);
        play_round(1'b0);

        // Abandon a round with reset mid-collect
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vv = 5'b00001; vy = 5'b00001;
        @(posedge clk); #1;
        vv = 5'b00010; vy = 5'b00000;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_round_reset");
        vv = '0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Fresh directed round after reset, then random rounds
        set_plan(1, 2, 2, 1, 4, 5'b11010);
        play_round(1'b1);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 5; i++) begin
                int s;
                s = int'($urandom_range(0, 9));
                if (s == 0)      arr[i] = 0;
                else if (s <= 7) arr[i] = int'($urandom_range(1, 5));
                else             arr[i] = int'($urandom_range(6, 20));
                val[i] = 1'($urandom);
            end
            play_round(1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("a.rounds_outstanding", q_a.size(), 0);
        check("b.rounds_outstanding", q_b.size(), 0);
        check("c.rounds_outstanding", q_c.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
